// File: rtl/mult_sequencer_if.sv
// Request/result bundle between decode/control and the multiply sequencer.
// The master issues start with operands; the slave returns busy/done and the HI/LO product.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_sequencer.sv
// Unsigned WIDTHxWIDTH shift-add multiplier driving an external adder; WIDTH RUN cycles, done the cycle after.
// No backpressure: start is sampled only in IDLE/DONE and silently ignored while busy.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_sequencer_if.slave  req,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] p_next;

    // The adder is only ours while RUN; elsewhere it sees zeros.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a = p_q[2*WIDTH-1:WIDTH];
            add_b = p_q[0] ? m_q : '0;
        end
    end

    // Carry-out becomes the new top bit so no product bit is lost in the shift.
    assign p_next = {add_cout, add_sum, p_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (req.start) begin
                    m_d     = req.multiplicand;
                    p_d     = {{WIDTH{1'b0}}, req.multiplier};
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d    = p_next;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = p_next[2*WIDTH-1:WIDTH];
                    lo_d    = p_next[WIDTH-1:0];
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign req.busy = busy_q;
    assign req.done = done_q;
    assign req.hi   = hi_q;
    assign req.lo   = lo_q;
endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle controller for unsigned 32x32 MULTU; drives the shared 32-bit carry-lookahead adder through a shift-add loop, one iteration per cycle.
- Writes the 64-bit product to HI/LO result registers.
- Sits between the decode/control unit and the adder. The adder stays purely combinational and outside this block; the sequencer owns its operand inputs while running.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- multiplicand  in  WIDTH  operand M, latched on accepted start
- multiplier  in  WIDTH  operand Q, latched on accepted start
- add_a  out  WIDTH  adder operand A
- add_b  out  WIDTH  adder operand B
- add_cin  out  1  adder carry-in
- add_sum  in  WIDTH  adder sum, same cycle, combinational
- add_cout  in  1  adder carry-out
- busy  out  1  high while iterating
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
- lo  out  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; internal M, P, count cleared. Reset mid-run aborts the operation with no partial result; the next start begins fresh.
- Internal registers:
  - M (WIDTH)
  - P (2*WIDTH): P_hi = P[2W-1:W], P_lo = P[W-1:0]
  - count (log2 WIDTH bits)
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge: M<=multiplicand, P<={0, multiplier}, count<=0, go RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - add_a=P_hi; add_b = P[0] ? M : 0; add_cin=0.
  - At edge: P <= {add_cout, add_sum, P_lo[W-1:1]}; count <= count+1.
  - When count==WIDTH-1 at the edge: hi/lo <= final P (the shifted value being written that edge); go DONE.
  - start ignored while in RUN.
- DONE (one cycle): done=1; busy=0.
  - start=1 at edge: accepted exactly as in IDLE, go RUN (back-to-back).
  - Otherwise go IDLE.
- Adder outputs outside RUN: add_a=0, add_b=0, add_cin=0.
- busy=1 only in RUN; done=1 only in DONE. The two are never high together.
- hi/lo update only on the final RUN edge; they hold the previous result throughout a new computation, and after reset read 0.
- Latency: start accepted at edge E0 -> RUN for edges E1..E32 -> done high in the cycle after E32. The next accepted start is at E33 at the earliest.
- Operands may change after acceptance without effect.
- Arithmetic: exact unsigned 64-bit product, no overflow possible. The adder carry-out is preserved as the new top bit each iteration.
- Multiplier=0 or multiplicand=0 still takes the full WIDTH cycles; there is no early termination.

Test Plan:
- Basic: reset, then start with M=3, Q=5 -> busy high for 32 cycles, done pulse 33 cycles after start edge, hi=0x00000000, lo=0x0000000F.
- Maximum operands: M=0xFFFFFFFF, Q=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; add_cout observed high in at least one RUN cycle.
- Carry across halves: M=0x80000000, Q=2 -> hi=0x00000001, lo=0x00000000. Also M=0x12345678, Q=0x9ABCDEF0 -> hi=0x0B00EA4E, lo=0x242D2080.
- Start while busy: start with M=7, Q=6, then start with M=1, Q=1 pulsed at cycle 10 -> second request ignored, result lo=42, exactly one done pulse. Operand changes after E0 do not alter the result.
- Back-to-back: start held high through DONE with new operands M=10, Q=10 -> first result valid at done, second run begins with no IDLE cycle, second done 33 cycles later with lo=100; hi/lo hold the first result until the second completes.
- Reset mid-operation: start M=9, Q=9, assert rst_n=0 at cycle 12 -> busy/done/hi/lo immediately 0, adder outputs 0. After release, start M=2, Q=3 -> lo=6 after full latency.
